// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer for the pipelined RAT core: synchronises int_in,
// latches edges, and walks flush -> return-PC push -> vector load -> ISR until RETIE.
module interrupt_sequencer #(
  parameter int                  PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = 10'h3FF,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                int_in,
  input  logic                int_en_set,
  input  logic                int_en_clr,
  input  logic                retie,
  input  logic                safe_point,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic                stk_push_ack,
  output logic                stk_push_req,
  output logic [PC_WIDTH-1:0] stk_push_data,
  output logic                pipe_flush,
  output logic                pc_load_vec,
  output logic [PC_WIDTH-1:0] vec_addr,
  output logic                flags_save,
  output logic                flags_restore,
  output logic                ie_flag,
  output logic                int_pending,
  output logic                int_active
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SAFE,
    FLUSH,
    PUSH,
    VECTOR,
    IN_ISR
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   pending_q, pending_d;
  logic                   ie_q, ie_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [PC_WIDTH-1:0]    ret_pc_q, ret_pc_d;
  logic                   pipe_flush_q, pipe_flush_d;
  logic                   push_req_q, push_req_d;
  logic                   load_vec_q, load_vec_d;
  logic                   save_q, save_d;
  logic                   restore_q, restore_d;
  logic                   active_q, active_d;
  logic                   rise;
  logic                   enter_flush;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], int_in};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    rise        = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    enter_flush = (state_q == WAIT_SAFE) && ie_q && safe_point;

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE:      if (pending_q && ie_q) state_d = WAIT_SAFE;
      WAIT_SAFE: begin
        if (!ie_q) begin
          state_d = IDLE;
        end else if (safe_point) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = PUSH;
        else                           flush_cnt_d = flush_cnt_q + 3'd1;
      end
      PUSH:    if (stk_push_ack) state_d = VECTOR;
      VECTOR:  state_d = IN_ISR;
      IN_ISR:  if (retie) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh edge in the same cycle as the entry clear must survive.
    pending_d = rise | (pending_q & ~enter_flush);

    ie_d = ie_q;
    if (retie || int_en_set) ie_d = 1'b1;
    if (int_en_clr)          ie_d = 1'b0;
    if (enter_flush)         ie_d = 1'b0;

    ret_pc_d = enter_flush ? ex_pc : ret_pc_q;

    // Outputs are decoded from the next state so they register alongside it.
    pipe_flush_d = (state_d == FLUSH) || (state_d == PUSH) || (state_d == VECTOR);
    push_req_d   = (state_d == PUSH);
    load_vec_d   = (state_d == VECTOR);
    active_d     = pipe_flush_d || (state_d == IN_ISR);
    save_d       = enter_flush;
    restore_d    = (state_q == IN_ISR) && retie;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      sync_prev_q  <= 1'b0;
      pending_q    <= 1'b0;
      ie_q         <= 1'b0;
      flush_cnt_q  <= '0;
      ret_pc_q     <= '0;
      pipe_flush_q <= 1'b0;
      push_req_q   <= 1'b0;
      load_vec_q   <= 1'b0;
      save_q       <= 1'b0;
      restore_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      sync_prev_q  <= sync_prev_d;
      pending_q    <= pending_d;
      ie_q         <= ie_d;
      flush_cnt_q  <= flush_cnt_d;
      ret_pc_q     <= ret_pc_d;
      pipe_flush_q <= pipe_flush_d;
      push_req_q   <= push_req_d;
      load_vec_q   <= load_vec_d;
      save_q       <= save_d;
      restore_q    <= restore_d;
      active_q     <= active_d;
    end
  end

  assign stk_push_req  = push_req_q;
  assign stk_push_data = ret_pc_q;
  assign pipe_flush    = pipe_flush_q;
  assign pc_load_vec   = load_vec_q;
  assign vec_addr      = VECTOR_ADDR;
  assign flags_save    = save_q;
  assign flags_restore = restore_q;
  assign ie_flag       = ie_q;
  assign int_pending   = pending_q;
  assign int_active    = active_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed table, corner sequences,
// and random stimulus against a cycle-level behavioural model.
module tb_interrupt_sequencer;

  localparam int         PW  = 10;
  localparam int         S   = 2;
  localparam int         FC  = 2;
  localparam logic [9:0] VEC = 10'h3FF;

  logic          clk = 1'b0;
  logic          reset, int_in, int_en_set, int_en_clr, retie, safe_point, stk_push_ack;
  logic [PW-1:0] ex_pc;
  logic          stk_push_req, pipe_flush, pc_load_vec, flags_save, flags_restore;
  logic          ie_flag, int_pending, int_active;
  logic [PW-1:0] stk_push_data, vec_addr;

  interrupt_sequencer #(
    .PC_WIDTH(PW), .VECTOR_ADDR(VEC), .SYNC_STAGES(S), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .int_in(int_in), .int_en_set(int_en_set),
    .int_en_clr(int_en_clr), .retie(retie), .safe_point(safe_point), .ex_pc(ex_pc),
    .stk_push_ack(stk_push_ack), .stk_push_req(stk_push_req), .stk_push_data(stk_push_data),
    .pipe_flush(pipe_flush), .pc_load_vec(pc_load_vec), .vec_addr(vec_addr),
    .flags_save(flags_save), .flags_restore(flags_restore), .ie_flag(ie_flag),
    .int_pending(int_pending), .int_active(int_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // int_in history and an entry described by "flush cycles remaining", "push
  // outstanding", "vector cycle" and "in ISR" rather than a state code.
  bit         h [0:S];
  bit         m_ie, m_pend, m_wait, m_push, m_vec, m_isr, m_save, m_restore;
  int         m_fl;
  logic [9:0] m_retpc = '0;

  function automatic logic [17:0] dut_vec();
    return {stk_push_req, stk_push_data, pipe_flush, pc_load_vec, flags_save,
            flags_restore, ie_flag, int_pending, int_active};
  endfunction

  function automatic logic [17:0] model_vec();
    bit flush;
    flush = (m_fl > 0) || m_push || m_vec;
    return {m_push, m_retpc, flush, m_vec, m_save, m_restore, m_ie, m_pend, flush || m_isr};
  endfunction

  task automatic model_step();
    bit idle, enter, edge_seen, n_ie;
    if (reset) begin
      for (int i = 0; i <= S; i++) h[i] = 1'b0;
      {m_ie, m_pend, m_wait, m_push, m_vec, m_isr, m_save, m_restore} = '0;
      m_fl    = 0;
      m_retpc = '0;
      return;
    end
    edge_seen = h[S-1] && !h[S];
    idle      = !m_wait && m_fl == 0 && !m_push && !m_vec && !m_isr;
    enter     = m_wait && m_ie && safe_point;
    n_ie = m_ie;
    if (retie || int_en_set) n_ie = 1'b1;
    if (int_en_clr)          n_ie = 1'b0;
    if (enter)               n_ie = 1'b0;
    m_restore = m_isr && retie;
    m_isr     = m_vec || (m_isr && !retie);
    m_vec     = m_push && stk_push_ack;
    m_push    = (m_fl == 1) || (m_push && !stk_push_ack);
    m_fl      = enter ? FC : (m_fl > 0 ? m_fl - 1 : 0);
    m_wait    = idle ? (m_pend && m_ie) : (m_wait && m_ie && !safe_point);
    m_save    = enter;
    if (enter) m_retpc = ex_pc;
    m_pend    = edge_seen || (m_pend && !enter);
    m_ie      = n_ie;
    for (int i = S; i > 0; i--) h[i] = h[i-1];
    h[0] = int_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", {14'd0, dut_vec()}, {14'd0, model_vec()});
  endtask

  task automatic clear_inputs();
    {int_in, int_en_set, int_en_clr, retie, safe_point, stk_push_ack} = '0;
    ex_pc = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    chk("reset_state", {14'd0, dut_vec()}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_int();
    int_in = 1'b1;
    tick();
    int_in = 1'b0;
  endtask

  task automatic sei();
    int_en_set = 1'b1;
    tick();
    int_en_set = 1'b0;
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max && !stk_push_req; i++) tick();
    chk("wait_req_bound", {31'd0, stk_push_req}, 32'd1);
  endtask

  // ---------------- directed table: basic entry ----------------
  typedef struct {
    bit         intin, sei, safe, ack;
    logic [9:0] pc;
    bit         req, flush, pcl, save, ie, pend, act;
    logic [9:0] data;
  } row_t;

  row_t tbl [10];

  initial begin
    //           in sei sf ack pc      req fl pcl sv ie pd act data
    tbl[0] = '{0, 1, 0, 0, 10'h000, 0, 0, 0, 0, 1, 0, 0, 10'h000};
    tbl[1] = '{1, 0, 1, 1, 10'h042, 0, 0, 0, 0, 1, 0, 0, 10'h000};
    tbl[2] = '{0, 0, 1, 1, 10'h042, 0, 0, 0, 0, 1, 0, 0, 10'h000};
    tbl[3] = '{0, 0, 1, 1, 10'h042, 0, 0, 0, 0, 1, 1, 0, 10'h000};
    tbl[4] = '{0, 0, 1, 1, 10'h042, 0, 0, 0, 0, 1, 1, 0, 10'h000};
    tbl[5] = '{0, 0, 1, 1, 10'h042, 0, 1, 0, 1, 0, 0, 1, 10'h042};
    tbl[6] = '{0, 0, 1, 1, 10'h042, 0, 1, 0, 0, 0, 0, 1, 10'h042};
    tbl[7] = '{0, 0, 1, 1, 10'h042, 1, 1, 0, 0, 0, 0, 1, 10'h042};
    tbl[8] = '{0, 0, 1, 1, 10'h042, 0, 1, 1, 0, 0, 0, 1, 10'h042};
    tbl[9] = '{0, 0, 1, 1, 10'h042, 0, 0, 0, 0, 0, 0, 1, 10'h042};

    reset = 1'b1;
    clear_inputs();
    do_reset();
    chk("vec_addr", {22'd0, vec_addr}, {22'd0, VEC});

    foreach (tbl[i]) begin
      int_in       = tbl[i].intin;
      int_en_set   = tbl[i].sei;
      safe_point   = tbl[i].safe;
      stk_push_ack = tbl[i].ack;
      ex_pc        = tbl[i].pc;
      tick();
      chk($sformatf("entry_row%0d", i), {14'd0, dut_vec()},
          {14'd0, tbl[i].req, tbl[i].data, tbl[i].flush, tbl[i].pcl, tbl[i].save,
           1'b0, tbl[i].ie, tbl[i].pend, tbl[i].act});
    end

    // Nested edge during ISR: latched, no re-entry until RETIE.
    pulse_int();
    repeat (6) tick();
    chk("nested_pending", {29'd0, int_pending, pipe_flush, int_active}, {29'd0, 3'b101});
    retie = 1'b1;
    tick();
    retie = 1'b0;
    chk("retie_restore", {29'd0, flags_restore, ie_flag, int_active}, {29'd0, 3'b110});
    tick();
    chk("restore_one_cycle", {31'd0, flags_restore}, 32'd0);
    tick();
    chk("reentry_flush", {30'd0, pipe_flush, flags_save}, {30'd0, 2'b11});

    // Masked interrupt, then SEI lets entry proceed.
    do_reset();
    safe_point   = 1'b1;
    stk_push_ack = 1'b1;
    pulse_int();
    repeat (3) tick();
    chk("masked_pending", {30'd0, int_pending, pipe_flush}, {30'd0, 2'b10});
    repeat (10) tick();
    chk("masked_hold", {29'd0, int_pending, pipe_flush, ie_flag}, {29'd0, 3'b100});
    sei();
    chk("masked_sei", {31'd0, ie_flag}, 32'd1);
    tick();
    tick();
    chk("masked_entry", {30'd0, pipe_flush, int_pending}, {30'd0, 2'b10});

    // Safe-point wait, then CLI drops back to idle keeping pending.
    do_reset();
    sei();
    pulse_int();
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("safe_wait", {30'd0, pipe_flush, int_pending}, {30'd0, 2'b01});
    end
    int_en_clr = 1'b1;
    tick();
    int_en_clr = 1'b0;
    tick();
    chk("cli_keeps_pending", {29'd0, int_pending, ie_flag, pipe_flush}, {29'd0, 3'b100});
    sei();
    safe_point = 1'b1;
    tick();
    tick();
    chk("resume_after_cli", {31'd0, pipe_flush}, 32'd1);

    // Stack backpressure: ack withheld for three PUSH cycles.
    do_reset();
    sei();
    ex_pc      = 10'h155;
    safe_point = 1'b1;
    pulse_int();
    wait_req(30);
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_hold", {20'd0, stk_push_req, pc_load_vec, stk_push_data},
          {20'd0, 1'b1, 1'b0, 10'h155});
      if (i < 3) tick();
    end
    stk_push_ack = 1'b1;
    tick();
    stk_push_ack = 1'b0;
    chk("bp_vector", {30'd0, stk_push_req, pc_load_vec}, {30'd0, 2'b01});

    // Reset in the middle of PUSH abandons the sequence.
    do_reset();
    sei();
    safe_point = 1'b1;
    pulse_int();
    wait_req(30);
    reset = 1'b1;
    tick();
    chk("reset_mid_push", {14'd0, dut_vec()}, 32'd0);
    reset = 1'b0;
    tick();
    chk("after_reset_idle", {30'd0, pipe_flush, stk_push_req}, 32'd0);

    // SEI/CLI collision: clear wins.
    sei();
    int_en_set = 1'b1;
    int_en_clr = 1'b1;
    tick();
    int_en_set = 1'b0;
    int_en_clr = 1'b0;
    chk("sei_cli_collision", {31'd0, ie_flag}, 32'd0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(127) == 0);
      if ($urandom_range(7) == 0) int_in = ~int_in;
      int_en_set   = ($urandom_range(7) == 0);
      int_en_clr   = ($urandom_range(31) == 0);
      retie        = ($urandom_range(9) == 0);
      safe_point   = ($urandom_range(1) == 0);
      stk_push_ack = ($urandom_range(1) == 0);
      ex_pc        = 10'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
